mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//   Load/store unit for the MEM stage of the RV32I pipeline; sits between EX/MEM and MEM/WB regs.
//   Takes op_load/op_store requests (load_funct3_t / store_funct3_t, byte address, store data).
//   Runs a single-outstanding req/resp handshake with the data cache.
//   Produces lane-aligned, sign/zero-extended load data and a pipeline stall.
// PARAMETERS
//   WAIT_CNT_W   8   width of saturating per-access wait-cycle counter (wait_cycles)
// PORTS
//   clk          in   1   clock; all state updates on rising edge
//   rst          in   1   synchronous reset, active-high
//   req_valid    in   1   EX/MEM holds a memory op this cycle
//   req_store    in   1   1 = store (store_funct3_t), 0 = load (load_funct3_t)
//   funct3       in   3   funct3 of the op
//   addr         in   32  byte address (rv32i_word)
//   wdata        in   32  rs2 value for stores
//   stall        out  1   freeze upstream pipeline regs
//   resp_valid   out  1   one-cycle pulse: access complete; load_data valid
//   load_data    out  32  extended load result (0 after a store)
//   wait_cycles  out  WAIT_CNT_W  cycles spent in ACCESS for last access, saturating
//   dmem_address out  32  word-aligned address {addr[31:2],2'b00}
//   dmem_read    out  1   cache read strobe
//   dmem_write   out  1   cache write strobe
//   dmem_wmask   out  4   byte-enable (rv32i_mem_wmask)
//   dmem_wdata   out  32  store data shifted into its lanes
//   dmem_rdata   in   32  cache read word
//   dmem_resp    in   1   cache done (1 cycle)
// BEHAVIOUR
//   Reset: state=IDLE; every output 0; captured addr/funct3/wdata regs 0.
//   FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: req_valid=1 captures req_store/funct3/addr/wdata -> ACCESS; stall=req_valid (comb).
//   ACCESS: dmem_read=!st, dmem_write=st; address/mask/data from captured regs only.
//     Strobes held constant until dmem_resp. stall=1. wait counter +1 per cycle, saturates at all-ones.
//   dmem_resp in ACCESS: register extended load word into load_data (0 for stores);
//     latch counter into wait_cycles; -> DONE.
//   DONE: strobes 0, resp_valid=1, stall=0 -> IDLE; new req_valid ignored until IDLE.
//   Latency: cache resp N cycles after strobe rises -> resp_valid N+1 cycles after accept.
//   dmem_resp outside ACCESS: ignored.
//   Store lanes (o=addr[1:0]): sb wmask=4'b0001<<o, byte replicated x4;
//     sh wmask=4'b0011<<{o[1],1'b0}, half replicated x2; sw wmask=4'b1111.
//   Load extract: lb/lbu byte o, lh/lhu half o[1]; lb/lh sign-, lbu/lhu zero-extend to 32; lw as-is.
//   Undefined funct3 (e.g. 3'b011): treated as lw/sw.
//   rst mid-ACCESS: strobes drop next edge, no resp_valid; late dmem_resp ignored.
// CONFIGURATION
//   MEM_STAGE_LSU_MISALIGN_TRAP_EN defined:
//     half at odd addr / word with addr[1:0]!=0 -> IDLE->DONE in one cycle, no dmem strobe;
//     extra output misalign (1 bit) pulses with resp_valid; load_data=0, wait_cycles=0.
//   Not defined: no misalign port; half uses addr[1], word ignores addr[1:0] (forced aligned).
// TESTING
//   lw @0x100, resp after 3 cycles, rdata=0xDEADBEEF -> addr 0x100, read held 3 cycles,
//     load_data=0xDEADBEEF, wait_cycles=3, one resp_valid pulse.
//   lb @0x103 rdata=0x80123456 -> 0xFFFFFF80; lbu -> 0x00000080; lh @0x102 -> 0xFFFF8012.
//   sb @0x201 wdata=0x000000AB -> dmem_address=0x200, wmask=0010, wdata=0xABABABAB, load_data=0.
//   sh @0x202 wdata=0x1234 -> wmask=1100, wdata=0x12341234; sw -> wmask=1111.
//   rst in ACCESS, dmem_resp next cycle -> FSM IDLE, no resp_valid, outputs 0.
//   trap EN: lw @0x101 -> misalign+resp_valid 1 cycle after accept, no strobe; disabled: reads 0x100.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// RV32I MEM-stage load/store unit: single-outstanding data-cache handshake, lane steering, load extension.
// Optional build macro MEM_STAGE_LSU_MISALIGN_TRAP_EN: misaligned half/word ops complete at once with a misalign pulse.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | waiting for req_valid; captures the op on acceptance
//  ACCESS | cache strobe held until dmem_resp; pipeline stalled
//  DONE   | one-cycle resp_valid; new requests ignored
module mem_stage_lsu #(
    parameter int WAIT_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_store,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [31:0]           load_data,
    output logic [WAIT_CNT_W-1:0] wait_cycles,
`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
    output logic                  misalign,
`endif
    output logic [31:0]           dmem_address,
    output logic                  dmem_read,
    output logic                  dmem_write,
    output logic [3:0]            dmem_wmask,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                  state;
    logic                    cap_store;
    logic [2:0]              cap_funct3;
    logic [31:0]             cap_addr;
    logic [31:0]             cap_wdata;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [WAIT_CNT_W-1:0]   wait_inc;
    logic                    trap_hit;
    logic                    dmem_active;
    logic [3:0]              lane_wmask;
    logic [31:0]             lane_wdata;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [31:0]             load_ext;

`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
    // Bytes never trap; halves need addr[0]=0; everything else is word-class.
    function automatic logic is_misaligned(input logic st, input logic [2:0] f3,
                                           input logic [1:0] o);
        logic is_byte;
        logic is_half;
        is_byte = (f3 == 3'b000) || (!st && f3 == 3'b100);
        is_half = (f3 == 3'b001) || (!st && f3 == 3'b101);
        if (is_byte)
            return 1'b0;
        if (is_half)
            return o[0];
        return (o != 2'b00);
    endfunction

    assign trap_hit = is_misaligned(req_store, funct3, addr[1:0]);
`else
    assign trap_hit = 1'b0;
`endif

    assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

    assign stall = ((state == S_IDLE) && req_valid) || (state == S_ACCESS);

    // Cache-facing fields come only from the captured op and are zero while no strobe is up.
    assign dmem_active  = dmem_read || dmem_write;
    assign dmem_address = dmem_active ? {cap_addr[31:2], 2'b00} : 32'd0;
    assign dmem_wmask   = dmem_write ? lane_wmask : 4'b0000;
    assign dmem_wdata   = dmem_write ? lane_wdata : 32'd0;

    always_comb begin
        lane_wmask = 4'b1111;
        lane_wdata = cap_wdata;
        case (cap_funct3)
            3'b000: begin
                lane_wmask = 4'b0001 << cap_addr[1:0];
                lane_wdata = {4{cap_wdata[7:0]}};
            end
            3'b001: begin
                lane_wmask = cap_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{cap_wdata[15:0]}};
            end
            default: begin
                lane_wmask = 4'b1111;
                lane_wdata = cap_wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (cap_addr[1:0])
            2'd0: byte_sel = dmem_rdata[7:0];
            2'd1: byte_sel = dmem_rdata[15:8];
            2'd2: byte_sel = dmem_rdata[23:16];
            2'd3: byte_sel = dmem_rdata[31:24];
            default: byte_sel = dmem_rdata[7:0];
        endcase
        half_sel = cap_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_ext = dmem_rdata;
        case (cap_funct3)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cap_store   <= 1'b0;
            cap_funct3  <= 3'd0;
            cap_addr    <= 32'd0;
            cap_wdata   <= 32'd0;
            wait_cnt    <= '0;
            wait_cycles <= '0;
            load_data   <= 32'd0;
            resp_valid  <= 1'b0;
            dmem_read   <= 1'b0;
            dmem_write  <= 1'b0;
`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        cap_store  <= req_store;
                        cap_funct3 <= funct3;
                        cap_addr   <= addr;
                        cap_wdata  <= wdata;
                        wait_cnt   <= '0;
                        if (trap_hit) begin
                            state       <= S_DONE;
                            resp_valid  <= 1'b1;
                            load_data   <= 32'd0;
                            wait_cycles <= '0;
`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
                            misalign    <= 1'b1;
`endif
                        end else begin
                            state      <= S_ACCESS;
                            dmem_read  <= !req_store;
                            dmem_write <= req_store;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_resp) begin
                        state       <= S_DONE;
                        dmem_read   <= 1'b0;
                        dmem_write  <= 1'b0;
                        resp_valid  <= 1'b1;
                        load_data   <= cap_store ? 32'd0 : load_ext;
                        wait_cycles <= wait_inc;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
                    misalign   <= 1'b0;
`endif
                end
                default: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    dmem_read  <= 1'b0;
                    dmem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
